regfile_wb_arbiter: RTL and testbench

Write-port arbiter and pending-write scoreboard for the 32×32 general register file, which has one write port and four read ports. It takes write-back requests from pipeline slot 0, pipeline slot 1 and the long-latency mul/div unit. Each cycle it grants at most one request and drives the register file's single write port from a register stage. It also keeps a busy bit per architectural register for outstanding long-latency results; issue logic uses these bits to stall dependent instructions.

---
 rtl/regfile_wb_arbiter_pkg.sv | 20 ++
 rtl/regfile_wb_arbiter_wb_scoreboard.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, write-back payload type and helpers for the register-file
// write-port arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned CNT_W    = 4;

  typedef struct packed {
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wb_req_t;

  // One-hot mask selecting a single architectural register.
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_AW-1:0] addr);
    reg_mask = NUM_REGS'(1) << addr;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set by
// long-latency reservations and cleared by mul/div write-back.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                rsv_valid,
  input  logic [REG_AW-1:0]   rsv_addr,
  output logic                rsv_ready,
  input  logic                clr_valid,
  input  logic [REG_AW-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                set_c;

  // Acceptance reads the pre-update bit, so a same-cycle clear never admits a set.
  always_comb begin
    rsv_ready = 1'b0;
    if (resetn) begin
      rsv_ready = (rsv_addr == '0) || !busy_q[rsv_addr];
    end
    set_c = rsv_valid && rsv_ready && (rsv_addr != '0);
  end

  always_comb begin
    busy_d = busy_q;
    if (clr_valid) begin
      busy_d = busy_d & ~reg_mask(clr_addr);
    end
    if (set_c) begin
      busy_d = busy_d | reg_mask(rsv_addr);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file: grants one of slot0, slot1
// or mul/div per cycle with req2 anti-starvation, and registers the write.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [REG_AW-1:0]   req0_waddr,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [REG_AW-1:0]   req1_waddr,
  input  logic [DATA_W-1:0]   req1_wdata,
  input  logic                req2_valid,
  output logic                req2_ready,
  input  logic [REG_AW-1:0]   req2_waddr,
  input  logic [DATA_W-1:0]   req2_wdata,
  input  logic                rsv_valid,
  input  logic [REG_AW-1:0]   rsv_addr,
  output logic                rsv_ready,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starve_c;
  logic             grant_c;
  wb_req_t          sel_c;
  logic             rf_we_q;
  wb_req_t          rf_q;

  assign starve_c = (starve_q == CNT_W'(STARVE_MAX));

  // Fixed priority req0 > req1 > req2, overridden by a starved req2.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    req2_ready = 1'b0;
    if (resetn) begin
      if (req2_valid && starve_c) begin
        req2_ready = 1'b1;
      end else if (req0_valid) begin
        req0_ready = 1'b1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
      end else if (req2_valid) begin
        req2_ready = 1'b1;
      end
    end
  end

  always_comb begin
    grant_c = 1'b0;
    sel_c   = '0;
    if (req0_valid && req0_ready) begin
      grant_c = 1'b1;
      sel_c   = '{waddr: req0_waddr, wdata: req0_wdata};
    end else if (req1_valid && req1_ready) begin
      grant_c = 1'b1;
      sel_c   = '{waddr: req1_waddr, wdata: req1_wdata};
    end else if (req2_valid && req2_ready) begin
      grant_c = 1'b1;
      sel_c   = '{waddr: req2_waddr, wdata: req2_wdata};
    end
  end

  always_comb begin
    starve_d = '0;
    if (req2_valid && !req2_ready) begin
      starve_d = starve_c ? starve_q : starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
      rf_we_q  <= 1'b0;
      rf_q     <= '0;
    end else begin
      starve_q <= starve_d;
      rf_we_q  <= grant_c && (sel_c.waddr != '0);
      if (grant_c) begin
        rf_q <= sel_c;
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_q.waddr;
  assign rf_wdata = rf_q.wdata;

  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .resetn    (resetn),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .clr_valid (req2_valid && req2_ready),
    .clr_addr  (req2_waddr),
    .busy_vec  (busy_vec)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// constrained-random traffic against a cycle-level reference model.
module tb_regfile_wb_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req0_valid, req1_valid, req2_valid, rsv_valid;
  logic        req0_ready, req1_ready, req2_ready, rsv_ready;
  logic [4:0]  req0_waddr, req1_waddr, req2_waddr, rsv_addr;
  logic [31:0] req0_wdata, req1_wdata, req2_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_vec;

  regfile_wb_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_waddr(req0_waddr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_waddr(req1_waddr), .req1_wdata(req1_wdata),
    .req2_valid(req2_valid), .req2_ready(req2_ready), .req2_waddr(req2_waddr), .req2_wdata(req2_wdata),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: how long req2 has been kept waiting, pending bits,
  // and the write the register file should currently be seeing.
  int          m_wait;
  bit          m_busy [32];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          t0, t1, t2;
  int          we_count;
  bit          r2_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    m_wait = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_we = 1'b0; m_waddr = '0; m_wdata = '0;
  endtask

  // One clock: check handshakes now, then the registered state after the edge.
  task automatic cycle();
    bit e0, e1, e2, ersv, starved;
    #1;
    starved = req2_valid && (m_wait >= SM);
    e2   = req2_valid && (starved || (!req0_valid && !req1_valid));
    e0   = req0_valid && !starved;
    e1   = req1_valid && !req0_valid && !starved;
    ersv = (rsv_addr == 5'd0) || !m_busy[rsv_addr];
    chk("req0_ready", 32'(req0_ready), 32'(e0));
    chk("req1_ready", 32'(req1_ready), 32'(e1));
    chk("req2_ready", 32'(req2_ready), 32'(e2));
    chk("rsv_ready",  32'(rsv_ready),  32'(ersv));
    t0 = e0; t1 = e1; t2 = e2;
    if (e2) r2_seen = 1'b1;
    if (e0 || e1 || e2) begin
      m_waddr = e0 ? req0_waddr : (e1 ? req1_waddr : req2_waddr);
      m_wdata = e0 ? req0_wdata : (e1 ? req1_wdata : req2_wdata);
      m_we    = (m_waddr != 5'd0);
    end else begin
      m_we = 1'b0;
    end
    if (e2) m_busy[req2_waddr] = 1'b0;
    if (rsv_valid && ersv && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
    m_wait = (req2_valid && !e2) ? ((m_wait < SM) ? m_wait + 1 : SM) : 0;
    @(posedge clk);
    #1;
    chk("rf_we",    32'(rf_we),    32'(m_we));
    chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
    chk("rf_wdata", rf_wdata,      m_wdata);
    chk("busy_vec", busy_vec,      model_busy());
    if (rf_we) we_count++;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; req2_valid = 0; rsv_valid = 0;
    req0_waddr = '0; req1_waddr = '0; req2_waddr = '0; rsv_addr = '0;
    req0_wdata = '0; req1_wdata = '0; req2_wdata = '0;
  endtask

  initial begin
    // Reset with every requester asserting.
    idle_inputs();
    resetn = 1'b0;
    req0_valid = 1; req0_waddr = 5'd1; req0_wdata = 32'h1111;
    req1_valid = 1; req1_waddr = 5'd2; req1_wdata = 32'h2222;
    req2_valid = 1; req2_waddr = 5'd3; req2_wdata = 32'h3333;
    rsv_valid  = 1; rsv_addr   = 5'd4;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_req2_ready", 32'(req2_ready), 32'd0);
    chk("rst_rsv_ready",  32'(rsv_ready),  32'd0);
    chk("rst_rf_we",      32'(rf_we),      32'd0);
    chk("rst_rf_waddr",   32'(rf_waddr),   32'd0);
    chk("rst_rf_wdata",   rf_wdata,        32'd0);
    chk("rst_busy",       busy_vec,        32'd0);
    @(negedge clk);
    resetn = 1'b1;
    rsv_valid = 0; req1_valid = 0; req2_valid = 0;
    cycle();
    chk("first_grant_req0", 32'(t0), 32'd1);
    chk("first_write_addr", 32'(rf_waddr), 32'd1);

    // Program order between slots to the same register.
    @(negedge clk); idle_inputs();
    req0_valid = 1; req0_waddr = 5'd3; req0_wdata = 32'h11;
    req1_valid = 1; req1_waddr = 5'd3; req1_wdata = 32'h22;
    cycle();
    chk("order_first", rf_wdata, 32'h11);
    @(negedge clk); req0_valid = 0;
    cycle();
    chk("order_second", rf_wdata, 32'h22);

    // Starvation: req2 must win in the fifth waiting cycle.
    @(negedge clk); idle_inputs();
    req0_valid = 1; req0_waddr = 5'd5; req0_wdata = 32'h5;
    req2_valid = 1; req2_waddr = 5'd7; req2_wdata = 32'hABCD;
    r2_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      cycle();
      chk("starve_req2_grant_cycle", 32'(t2), 32'(c == 4));
    end
    chk("starve_rf_waddr", 32'(rf_waddr), 32'd7);
    @(negedge clk); req2_valid = 0;
    cycle();
    chk("starve_req0_resumes", 32'(t0), 32'd1);

    // Scoreboard set, blocked re-reservation, clear by req2.
    @(negedge clk); idle_inputs();
    rsv_valid = 1; rsv_addr = 5'd9;
    cycle();
    chk("sb_busy9_set", 32'(busy_vec[9]), 32'd1);
    @(negedge clk);
    #1 chk("sb_rereserve_blocked", 32'(rsv_ready), 32'd0);
    cycle();
    @(negedge clk); idle_inputs();
    req2_valid = 1; req2_waddr = 5'd9; req2_wdata = 32'h99;
    cycle();
    chk("sb_busy9_clear", 32'(busy_vec[9]), 32'd0);
    chk("sb_rf_we_r9", 32'(rf_we), 32'd1);

    // Register 0 handling.
    @(negedge clk); idle_inputs();
    req1_valid = 1; req1_waddr = 5'd0; req1_wdata = 32'hFFFF_FFFF;
    rsv_valid = 1; rsv_addr = 5'd0;
    cycle();
    chk("r0_req1_ready", 32'(t1), 32'd1);
    chk("r0_no_write", 32'(rf_we), 32'd0);
    chk("r0_busy_zero", busy_vec, 32'd0);

    // Back-to-back slot-0 stream.
    we_count = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); idle_inputs();
      req0_valid = 1; req0_waddr = 5'd10; req0_wdata = 32'h100 + 32'(i);
      cycle();
    end
    chk("b2b_write_count", 32'(we_count), 32'd8);

    // Mid-run reset drops everything.
    @(negedge clk);
    resetn = 1'b0; rsv_valid = 1; rsv_addr = 5'd12; req2_valid = 1;
    #1;
    model_reset();
    chk("midrst_req0_ready", 32'(req0_ready), 32'd0);
    chk("midrst_rf_we", 32'(rf_we), 32'd0);
    chk("midrst_busy", busy_vec, 32'd0);
    @(negedge clk); resetn = 1'b1; idle_inputs();
    t0 = 1; t1 = 1; t2 = 1;

    // Random traffic; held payloads respect the valid/ready rules.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!req0_valid || t0) begin
        req0_valid = ($urandom_range(0, 2) == 0);
        req0_waddr = 5'($urandom_range(0, 31)); req0_wdata = $urandom;
      end
      if (!req1_valid || t1) begin
        req1_valid = ($urandom_range(0, 1) == 0);
        req1_waddr = 5'($urandom_range(0, 31)); req1_wdata = $urandom;
      end
      if (!req2_valid || t2) begin
        req2_valid = ($urandom_range(0, 2) == 0);
        req2_waddr = 5'($urandom_range(0, 7)); req2_wdata = $urandom;
      end
      rsv_valid = ($urandom_range(0, 1) == 0);
      rsv_addr  = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
